// File: rtl/relu_instr_queue.sv
// rtl/relu_instr_queue.sv - in-order ReLU custom-instruction queue with accelerator hazard gate
// Optional zero-latency bypass of an empty queue is enabled by defining RELU_IQ_BYPASS_EN.
module relu_instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_rs1,
  input  logic [31:0]                in_rs2,
  input  logic [4:0]                 in_rd,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic [31:0]                rs1_val,
  output logic [31:0]                rs2_val,
  output logic [4:0]                 rd_addr,
  input  logic                       accel_busy,
  input  logic                       accel_done,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic                       q_empty,
  output logic                       illegal
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] F3_START = 3'b001;
  localparam logic [2:0] F3_STAT  = 3'b010;

  logic [100:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          start_pend;

  logic [31:0] head_instr, head_rs1, head_rs2;
  logic [4:0]  head_rd;
  logic        in_legal, accept, head_open, fifo_valid;
  logic        bypass, wr_en, deq, start_issued;

  assign {head_instr, head_rs1, head_rs2, head_rd} = mem[rd_ptr];

  assign q_empty  = (count == '0);
  assign q_full   = (count == CW'(DEPTH));
  assign q_count  = count;
  assign in_ready = !q_full;

  assign in_legal  = (in_instr[6:0] == 7'h33) && (in_instr[31:25] == 7'h03) && !in_instr[14];
  assign accept    = in_valid && in_ready;
  // STAT only reads status, so it may issue while the accelerator is computing.
  assign head_open = (head_instr[14:12] == F3_STAT) || (!accel_busy && !start_pend);
  assign fifo_valid = !q_empty && head_open && !rst;

`ifdef RELU_IQ_BYPASS_EN
  logic in_open;
  assign in_open = (in_instr[14:12] == F3_STAT) || (!accel_busy && !start_pend);
  assign bypass  = q_empty && in_open && in_legal && in_valid && instr_ready && !rst;
`else
  assign bypass  = 1'b0;
`endif

  assign wr_en = accept && in_legal && !bypass;
  assign deq   = fifo_valid && instr_ready;
  assign start_issued = (deq && head_instr[14:12] == F3_START) ||
                        (bypass && in_instr[14:12] == F3_START);

  always_comb begin
    instr_valid = fifo_valid || bypass;
    instr       = '0;
    rs1_val     = '0;
    rs2_val     = '0;
    rd_addr     = '0;
    if (bypass) begin
      instr   = in_instr;
      rs1_val = in_rs1;
      rs2_val = in_rs2;
      rd_addr = in_rd;
    end else if (!q_empty) begin
      instr   = head_instr;
      rs1_val = head_rs1;
      rs2_val = head_rs2;
      rd_addr = head_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {in_instr, in_rs1, in_rs2, in_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      start_pend <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (deq)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Bridges the gap between START leaving the queue and busy rising.
      if (start_issued)                  start_pend <= 1'b1;
      else if (accel_busy || accel_done) start_pend <= 1'b0;
      illegal <= accept && !in_legal;
    end
  end
endmodule
